// File: rtl/control_pkg.sv
// Shared RV32I encodings (rv32i_types) and controller-local state/mux-select types (ctrl_types).
package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [2:0] {
        add  = 3'b000,
        sll  = 3'b001,
        slt  = 3'b010,
        sltu = 3'b011,
        axor = 3'b100,
        sr   = 3'b101,
        aor  = 3'b110,
        aand = 3'b111
    } arith_funct3_t;

    typedef enum logic [2:0] {
        alu_add, alu_sll, alu_sra, alu_sub, alu_xor, alu_srl, alu_or, alu_and
    } alu_ops;

endpackage

package ctrl_types;

    typedef enum logic [4:0] {
        S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_IMM, S_REG, S_LUI, S_AUIPC, S_BR, S_JAL, S_JALR,
        S_CALC_ADDR, S_LD1, S_LD2, S_ST1, S_ST2,
        S_ILLEGAL
    } state_t;

    typedef enum logic [1:0] {
        pc_plus4    = 2'd0,
        pc_alu_out  = 2'd1,
        pc_alu_mod2 = 2'd2
    } pcmux_sel_t;

    typedef enum logic [2:0] {
        a2_i_imm = 3'd0,
        a2_u_imm = 3'd1,
        a2_b_imm = 3'd2,
        a2_s_imm = 3'd3,
        a2_j_imm = 3'd4,
        a2_rs2   = 3'd5
    } alumux2_sel_t;

    typedef enum logic [2:0] {
        rf_alu_out  = 3'd0,
        rf_br_en    = 3'd1,
        rf_u_imm    = 3'd2,
        rf_lw_data  = 3'd3,
        rf_pc_plus4 = 3'd4
    } regfilemux_sel_t;

    typedef enum logic [2:0] {
        ld_lb  = 3'd0,
        ld_lh  = 3'd1,
        ld_lw  = 3'd2,
        ld_lbu = 3'd3,
        ld_lhu = 3'd4
    } loadmux_sel_t;

    typedef enum logic [1:0] {
        st_sb = 2'd0,
        st_sh = 2'd1,
        st_sw = 2'd2
    } storemux_sel_t;

endpackage

// File: rtl/control_if.sv
// Memory port between the control FSM (master) and the memory (slave).
interface control_if;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] mem_byte_enable;
    logic       mem_resp;

    modport master (output mem_read, output mem_write, output mem_byte_enable, input mem_resp);
    modport slave  (input mem_read, input mem_write, input mem_byte_enable, output mem_resp);
endinterface

// File: rtl/control_funct_decode.sv
// Combinational funct3/funct7 decode: ALU op, compare op, load/store width and store byte lanes.
module ctrl_funct_decode
    import rv32i_types::*;
    import ctrl_types::*;
(
    input  logic [2:0]     funct3,
    input  logic [6:0]     funct7,
    input  logic [1:0]     mem_offset,
    output alu_ops         aluop_imm,
    output alu_ops         aluop_reg,
    output logic           is_slt,
    output branch_funct3_t cmpop_slt,
    output loadmux_sel_t   loadmux_sel,
    output storemux_sel_t  storemux_sel,
    output logic [3:0]     store_be
);

    alu_ops aluop_base;
    logic   alt;
    logic   funct7_unused;

    // Only funct7[5] selects sub/sra; the remaining bits carry no control meaning.
    assign alt           = funct7[5];
    assign funct7_unused = ^{funct7[6], funct7[4:0]};

    always_comb begin
        aluop_base = alu_add;
        case (arith_funct3_t'(funct3))
            add:     aluop_base = alu_add;
            sll:     aluop_base = alu_sll;
            axor:    aluop_base = alu_xor;
            sr:      aluop_base = alu_srl;
            aor:     aluop_base = alu_or;
            aand:    aluop_base = alu_and;
            default: aluop_base = alu_add;
        endcase
    end

    // Immediate forms: funct7 overlaps imm bits, so only the shift-right case looks at it.
    assign aluop_imm = (funct3 == 3'b101 && alt) ? alu_sra : aluop_base;

    always_comb begin
        aluop_reg = aluop_base;
        if (alt && funct3 == 3'b000)
            aluop_reg = alu_sub;
        else if (alt && funct3 == 3'b101)
            aluop_reg = alu_sra;
    end

    assign is_slt    = (funct3 == 3'b010) || (funct3 == 3'b011);
    assign cmpop_slt = (funct3 == 3'b011) ? bltu : blt;

    always_comb begin
        loadmux_sel = ld_lw;
        case (load_funct3_t'(funct3))
            lb:      loadmux_sel = ld_lb;
            lh:      loadmux_sel = ld_lh;
            lw:      loadmux_sel = ld_lw;
            lbu:     loadmux_sel = ld_lbu;
            lhu:     loadmux_sel = ld_lhu;
            default: loadmux_sel = ld_lw;
        endcase
    end

    always_comb begin
        storemux_sel = st_sw;
        store_be     = 4'b1111;
        case (store_funct3_t'(funct3))
            sb: begin
                storemux_sel = st_sb;
                store_be     = 4'b0001 << mem_offset;
            end
            sh: begin
                storemux_sel = st_sh;
                store_be     = 4'b0011 << {mem_offset[1], 1'b0};
            end
            default: begin
                storemux_sel = st_sw;
                store_be     = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/control.sv
// Multicycle RV32I control FSM: fetch / decode / execute / memory / writeback sequencing.
// Build option CTRL_ILLEGAL_TRAP_EN: unknown opcodes trap (sticky illegal_insn) instead of acting as a nop.
module control
    import rv32i_types::*;
    import ctrl_types::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            br_en,
    input  logic [1:0]      mem_offset,
    control_if.master       mem,
    output logic            load_pc,
    output logic            load_ir,
    output logic            load_regfile,
    output logic            load_mar,
    output logic            load_mdr,
    output logic            load_data_out,
    output pcmux_sel_t      pcmux_sel,
    output logic            alumux1_sel,
    output alumux2_sel_t    alumux2_sel,
    output regfilemux_sel_t regfilemux_sel,
    output loadmux_sel_t    loadmux_sel,
    output storemux_sel_t   storemux_sel,
    output logic            marmux_sel,
    output logic            cmpmux_sel,
    output alu_ops          aluop,
    output branch_funct3_t  cmpop,
    output logic            illegal_insn
);

    state_t         state, state_next;
    logic           mem_read_c, mem_write_c;
    logic [3:0]     byte_en_c;

    alu_ops         dec_aluop_imm, dec_aluop_reg;
    logic           dec_is_slt;
    branch_funct3_t dec_cmpop_slt;
    loadmux_sel_t   dec_loadmux;
    storemux_sel_t  dec_storemux;
    logic [3:0]     dec_store_be;

    ctrl_funct_decode u_decode (
        .funct3       (funct3),
        .funct7       (funct7),
        .mem_offset   (mem_offset),
        .aluop_imm    (dec_aluop_imm),
        .aluop_reg    (dec_aluop_reg),
        .is_slt       (dec_is_slt),
        .cmpop_slt    (dec_cmpop_slt),
        .loadmux_sel  (dec_loadmux),
        .storemux_sel (dec_storemux),
        .store_be     (dec_store_be)
    );

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= S_FETCH1;
        else
            state <= state_next;
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            illegal_q <= 1'b0;
        else if (state == S_ILLEGAL)
            illegal_q <= 1'b1;
    end

    assign illegal_insn = illegal_q;
`else
    assign illegal_insn = 1'b0;
`endif

    // Strobes decode purely from state so a reset mid-access drops them on the next cycle.
    assign mem.mem_read        = mem_read_c;
    assign mem.mem_write       = mem_write_c;
    assign mem.mem_byte_enable = byte_en_c;

    always_comb begin
        state_next     = state;
        load_pc        = 1'b0;
        load_ir        = 1'b0;
        load_regfile   = 1'b0;
        load_mar       = 1'b0;
        load_mdr       = 1'b0;
        load_data_out  = 1'b0;
        pcmux_sel      = pc_plus4;
        alumux1_sel    = 1'b0;
        alumux2_sel    = a2_i_imm;
        regfilemux_sel = rf_alu_out;
        loadmux_sel    = ld_lb;
        storemux_sel   = st_sb;
        marmux_sel     = 1'b0;
        cmpmux_sel     = 1'b0;
        aluop          = alu_add;
        cmpop          = branch_funct3_t'(funct3);
        mem_read_c     = 1'b0;
        mem_write_c    = 1'b0;
        byte_en_c      = 4'b1111;

        unique case (state)
            S_FETCH1: begin
                load_mar   = 1'b1;
                state_next = S_FETCH2;
            end
            S_FETCH2: begin
                mem_read_c = 1'b1;
                if (mem.mem_resp) begin
                    load_mdr   = 1'b1;
                    state_next = S_FETCH3;
                end
            end
            S_FETCH3: begin
                load_ir    = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                case (rv32i_opcode'(opcode))
                    op_imm:   state_next = S_IMM;
                    op_reg:   state_next = S_REG;
                    op_lui:   state_next = S_LUI;
                    op_auipc: state_next = S_AUIPC;
                    op_br:    state_next = S_BR;
                    op_jal:   state_next = S_JAL;
                    op_jalr:  state_next = S_JALR;
                    op_load,
                    op_store: state_next = S_CALC_ADDR;
                    default:  state_next = S_ILLEGAL;
                endcase
            end
            S_IMM: begin
                load_regfile = 1'b1;
                load_pc      = 1'b1;
                if (dec_is_slt) begin
                    cmpmux_sel     = 1'b1;
                    cmpop          = dec_cmpop_slt;
                    regfilemux_sel = rf_br_en;
                end else begin
                    aluop = dec_aluop_imm;
                end
                state_next = S_FETCH1;
            end
            S_REG: begin
                alumux2_sel  = a2_rs2;
                load_regfile = 1'b1;
                load_pc      = 1'b1;
                if (dec_is_slt) begin
                    cmpop          = dec_cmpop_slt;
                    regfilemux_sel = rf_br_en;
                end else begin
                    aluop = dec_aluop_reg;
                end
                state_next = S_FETCH1;
            end
            S_LUI: begin
                regfilemux_sel = rf_u_imm;
                load_regfile   = 1'b1;
                load_pc        = 1'b1;
                state_next     = S_FETCH1;
            end
            S_AUIPC: begin
                alumux1_sel  = 1'b1;
                alumux2_sel  = a2_u_imm;
                load_regfile = 1'b1;
                load_pc      = 1'b1;
                state_next   = S_FETCH1;
            end
            S_BR: begin
                alumux1_sel = 1'b1;
                alumux2_sel = a2_b_imm;
                pcmux_sel   = br_en ? pc_alu_out : pc_plus4;
                load_pc     = 1'b1;
                state_next  = S_FETCH1;
            end
            S_JAL: begin
                regfilemux_sel = rf_pc_plus4;
                load_regfile   = 1'b1;
                alumux1_sel    = 1'b1;
                alumux2_sel    = a2_j_imm;
                pcmux_sel      = pc_alu_out;
                load_pc        = 1'b1;
                state_next     = S_FETCH1;
            end
            S_JALR: begin
                // rd and PC load on the same edge, so rd still sees the old pc+4.
                regfilemux_sel = rf_pc_plus4;
                load_regfile   = 1'b1;
                pcmux_sel      = pc_alu_mod2;
                load_pc        = 1'b1;
                state_next     = S_FETCH1;
            end
            S_CALC_ADDR: begin
                marmux_sel = 1'b1;
                load_mar   = 1'b1;
                if (opcode == op_store) begin
                    alumux2_sel = a2_s_imm;
                    state_next  = S_ST1;
                end else begin
                    state_next  = S_LD1;
                end
            end
            S_LD1: begin
                mem_read_c = 1'b1;
                if (mem.mem_resp) begin
                    load_mdr   = 1'b1;
                    state_next = S_LD2;
                end
            end
            S_LD2: begin
                regfilemux_sel = rf_lw_data;
                loadmux_sel    = dec_loadmux;
                load_regfile   = 1'b1;
                load_pc        = 1'b1;
                state_next     = S_FETCH1;
            end
            S_ST1: begin
                storemux_sel  = dec_storemux;
                load_data_out = 1'b1;
                state_next    = S_ST2;
            end
            S_ST2: begin
                mem_write_c = 1'b1;
                byte_en_c   = dec_store_be;
                if (mem.mem_resp) begin
                    load_pc    = 1'b1;
                    state_next = S_FETCH1;
                end
            end
            S_ILLEGAL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                state_next = S_ILLEGAL;
`else
                load_pc    = 1'b1;
                state_next = S_FETCH1;
`endif
            end
            default: state_next = S_FETCH1;
        endcase
    end

endmodule

// File: tb/tb_control.sv
// Scoreboard bench for control: expected execute-cycle controls are queued at decode and checked on load_pc.
module tb_control;
    import rv32i_types::*;
    import ctrl_types::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ir = 32'h0;
    logic [31:0] fetch_word = 32'h0;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        br_en = 1'b0;
    logic [1:0]  mem_offset = 2'd0;

    logic load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out;
    pcmux_sel_t      pcmux_sel;
    logic            alumux1_sel;
    alumux2_sel_t    alumux2_sel;
    regfilemux_sel_t regfilemux_sel;
    loadmux_sel_t    loadmux_sel;
    storemux_sel_t   storemux_sel;
    logic            marmux_sel, cmpmux_sel;
    alu_ops          aluop;
    branch_funct3_t  cmpop;
    logic            illegal_insn;

    control_if mem_bus ();

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    always @(posedge clk) if (load_ir) ir <= fetch_word;

    control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .br_en(br_en), .mem_offset(mem_offset), .mem(mem_bus.master),
        .load_pc(load_pc), .load_ir(load_ir), .load_regfile(load_regfile), .load_mar(load_mar),
        .load_mdr(load_mdr), .load_data_out(load_data_out), .pcmux_sel(pcmux_sel),
        .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel), .regfilemux_sel(regfilemux_sel),
        .loadmux_sel(loadmux_sel), .storemux_sel(storemux_sel), .marmux_sel(marmux_sel),
        .cmpmux_sel(cmpmux_sel), .aluop(aluop), .cmpop(cmpop), .illegal_insn(illegal_insn)
    );

    typedef struct {
        pcmux_sel_t      pcmux;
        logic            alumux1;
        alumux2_sel_t    alumux2;
        regfilemux_sel_t rfmux;
        logic            load_rf;
        alu_ops          aluop;
        logic            cmpmux;
        branch_funct3_t  cmpop;
        loadmux_sel_t    ldmux;
        storemux_sel_t   stmux;
        logic [3:0]      be;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;

    function automatic exp_t model(input logic [31:0] insn, input logic br, input logic [1:0] off);
        exp_t e;
        logic [2:0] f3;
        logic       f7b5;
        f3 = insn[14:12];
        f7b5 = insn[30];
        e.pcmux = pc_plus4;  e.alumux1 = 1'b0;  e.alumux2 = a2_i_imm;  e.rfmux = rf_alu_out;
        e.load_rf = 1'b0;    e.aluop = alu_add; e.cmpmux = 1'b0;       e.cmpop = branch_funct3_t'(f3);
        e.ldmux = ld_lb;     e.stmux = st_sw;   e.be = 4'b1111;
        case (insn[6:0])
            op_imm, op_reg: begin
                e.load_rf = 1'b1;
                if (insn[6:0] == op_reg) e.alumux2 = a2_rs2;
                case (f3)
                    3'b000: e.aluop = (insn[6:0] == op_reg && f7b5) ? alu_sub : alu_add;
                    3'b001: e.aluop = alu_sll;
                    3'b010: begin e.rfmux = rf_br_en; e.cmpop = blt;  e.cmpmux = (insn[6:0] == op_imm); end
                    3'b011: begin e.rfmux = rf_br_en; e.cmpop = bltu; e.cmpmux = (insn[6:0] == op_imm); end
                    3'b100: e.aluop = alu_xor;
                    3'b101: e.aluop = f7b5 ? alu_sra : alu_srl;
                    3'b110: e.aluop = alu_or;
                    default: e.aluop = alu_and;
                endcase
            end
            op_lui:   begin e.rfmux = rf_u_imm; e.load_rf = 1'b1; end
            op_auipc: begin e.alumux1 = 1'b1; e.alumux2 = a2_u_imm; e.load_rf = 1'b1; end
            op_br:    begin e.alumux1 = 1'b1; e.alumux2 = a2_b_imm; e.pcmux = br ? pc_alu_out : pc_plus4; end
            op_jal:   begin e.rfmux = rf_pc_plus4; e.load_rf = 1'b1; e.alumux1 = 1'b1;
                            e.alumux2 = a2_j_imm; e.pcmux = pc_alu_out; end
            op_jalr:  begin e.rfmux = rf_pc_plus4; e.load_rf = 1'b1; e.pcmux = pc_alu_mod2; end
            op_load: begin
                e.rfmux = rf_lw_data; e.load_rf = 1'b1;
                case (f3)
                    3'b000: e.ldmux = ld_lb;
                    3'b001: e.ldmux = ld_lh;
                    3'b100: e.ldmux = ld_lbu;
                    3'b101: e.ldmux = ld_lhu;
                    default: e.ldmux = ld_lw;
                endcase
            end
            op_store: begin
                case (f3)
                    3'b000: begin e.stmux = st_sb; e.be = 4'b0001 << off; end
                    3'b001: begin e.stmux = st_sh; e.be = off[1] ? 4'b1100 : 4'b0011; end
                    default: begin e.stmux = st_sw; e.be = 4'b1111; end
                endcase
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered at FETCH1 (+1ns after the edge); returns in DECODE with the IR loaded.
    task automatic do_fetch(input logic [31:0] insn, input int wait_n, input bit stray);
        #1;
        checks++;
        if (load_mar !== 1'b1 || marmux_sel !== 1'b0 || mem_bus.mem_read !== 1'b0) begin
            errors++;
            $display("FAIL fetch1: load_mar=%b marmux=%b mem_read=%b, expected 1 0 0", load_mar, marmux_sel, mem_bus.mem_read);
        end
        if (stray) mem_bus.mem_resp = 1'b1;
        tick;
        mem_bus.mem_resp = 1'b0;
        for (int i = 0; i < wait_n; i++) begin
            #1;
            checks++;
            if (mem_bus.mem_read !== 1'b1 || load_mdr !== 1'b0) begin
                errors++;
                $display("FAIL fetch2_hold[%0d]: mem_read=%b load_mdr=%b, expected 1 0", i, mem_bus.mem_read, load_mdr);
            end
            tick;
        end
        mem_bus.mem_resp = 1'b1;
        fetch_word = insn;
        #1;
        checks++;
        if (mem_bus.mem_read !== 1'b1 || load_mdr !== 1'b1) begin
            errors++;
            $display("FAIL fetch2_resp: mem_read=%b load_mdr=%b, expected 1 1", mem_bus.mem_read, load_mdr);
        end
        tick;
        mem_bus.mem_resp = 1'b0;
        #1;
        checks++;
        if (load_ir !== 1'b1 || mem_bus.mem_read !== 1'b0) begin
            errors++;
            $display("FAIL fetch3: load_ir=%b mem_read=%b, expected 1 0", load_ir, mem_bus.mem_read);
        end
        tick;
    endtask

    task automatic exec(input string name, input logic [31:0] insn, input logic br,
                        input logic [1:0] off, input int wait_n);
        int   strobe_n;
        bit   done;
        exp_t e;
        strobe_n = 0;
        done = 1'b0;
        do_fetch(insn, 0, 1'b0);
        br_en = br;
        mem_offset = off;
        sb_q.push_back(model(insn, br, off));
        tick;
        for (int n = 0; n < 24 && !done; n++) begin
            if (mem_bus.mem_read || mem_bus.mem_write) begin
                mem_bus.mem_resp = (strobe_n >= wait_n);
                strobe_n++;
            end else begin
                mem_bus.mem_resp = 1'b0;
                strobe_n = 0;
            end
            #1;
            if (load_data_out) begin
                checks++;
                if (storemux_sel !== sb_q[0].stmux) begin
                    errors++;
                    $display("FAIL %s storemux: got %0d, expected %0d", name, storemux_sel, sb_q[0].stmux);
                end
            end
            if ((mem_bus.mem_read || mem_bus.mem_write) && !mem_bus.mem_resp) begin
                checks++;
                if (load_pc !== 1'b0 || load_mdr !== 1'b0) begin
                    errors++;
                    $display("FAIL %s strobe_hold: load_pc=%b load_mdr=%b, expected 0 0", name, load_pc, load_mdr);
                end
            end
            if (mem_bus.mem_read && mem_bus.mem_resp) begin
                checks++;
                if (load_mdr !== 1'b1) begin
                    errors++;
                    $display("FAIL %s load_mdr: got %b, expected 1", name, load_mdr);
                end
            end
            if (load_pc === 1'b1) begin
                e = sb_q.pop_front();
                checks++;
                if (pcmux_sel !== e.pcmux || alumux1_sel !== e.alumux1 || alumux2_sel !== e.alumux2 ||
                    regfilemux_sel !== e.rfmux || load_regfile !== e.load_rf || aluop !== e.aluop ||
                    cmpmux_sel !== e.cmpmux || cmpop !== e.cmpop || mem_bus.mem_byte_enable !== e.be ||
                    (e.rfmux == rf_lw_data && loadmux_sel !== e.ldmux)) begin
                    errors++;
                    $display("FAIL %s: got pc=%0d a1=%0d a2=%0d rf=%0d ldrf=%0b alu=%0d cm=%0d cmp=%0d ldm=%0d be=%b; expected pc=%0d a1=%0d a2=%0d rf=%0d ldrf=%0b alu=%0d cm=%0d cmp=%0d ldm=%0d be=%b",
                             name, pcmux_sel, alumux1_sel, alumux2_sel, regfilemux_sel, load_regfile, aluop,
                             cmpmux_sel, cmpop, loadmux_sel, mem_bus.mem_byte_enable,
                             e.pcmux, e.alumux1, e.alumux2, e.rfmux, e.load_rf, e.aluop, e.cmpmux, e.cmpop, e.ldmux, e.be);
                end
                done = 1'b1;
            end
            tick;
        end
        mem_bus.mem_resp = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: load_pc never asserted", name);
            void'(sb_q.pop_front());
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        checks++;
        if (load_mar !== 1'b1 || mem_bus.mem_read !== 1'b0 || mem_bus.mem_write !== 1'b0 ||
            mem_bus.mem_byte_enable !== 4'b1111 || load_pc !== 1'b0 || illegal_insn !== 1'b0 || aluop !== alu_add) begin
            errors++;
            $display("FAIL reset: load_mar=%b rd=%b wr=%b be=%b load_pc=%b illegal=%b alu=%0d, expected 1 0 0 1111 0 0 0",
                     load_mar, mem_bus.mem_read, mem_bus.mem_write, mem_bus.mem_byte_enable, load_pc, illegal_insn, aluop);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fetch_handshake;
        // Stray mem_resp in FETCH1 must be ignored; then three wait cycles in FETCH2.
        do_fetch(32'h00500093, 3, 1'b1);
        sb_q.push_back(model(32'h00500093, 1'b0, 2'd0));
        tick;
        #1;
        checks++;
        if (load_pc !== 1'b1) begin
            errors++;
            $display("FAIL handshake_imm: load_pc=%b, expected 1", load_pc);
        end else begin
            void'(sb_q.pop_front());
        end
        tick;
        if (sb_q.size() != 0) void'(sb_q.pop_front());
    endtask

    task automatic test_alu;
        exec("addi",  32'h00500093, 1'b0, 2'd0, 0);
        exec("slti",  32'hFFF0A113, 1'b0, 2'd0, 0);
        exec("srai",  32'h4020D193, 1'b0, 2'd0, 0);
        exec("xori",  32'h0FF0C213, 1'b0, 2'd0, 0);
        exec("add",   32'h002082B3, 1'b0, 2'd0, 0);
        exec("sub",   32'h402082B3, 1'b0, 2'd0, 0);
        exec("sltu",  32'h0020B333, 1'b0, 2'd0, 0);
        exec("sra",   32'h4020D3B3, 1'b0, 2'd0, 0);
        exec("lui",   32'h123450B7, 1'b0, 2'd0, 0);
        exec("auipc", 32'h00001117, 1'b0, 2'd0, 0);
        exec("jal",   32'h008000EF, 1'b0, 2'd0, 0);
    endtask

    task automatic test_branch;
        exec("beq_taken",    32'h00208463, 1'b1, 2'd0, 0);
        exec("beq_nottaken", 32'h00208463, 1'b0, 2'd0, 0);
    endtask

    task automatic test_mem;
        exec("sb_off3", 32'h002081A3, 1'b0, 2'd3, 2);
        exec("sh_off2", 32'h00209123, 1'b0, 2'd2, 1);
        exec("sw",      32'h0020A023, 1'b0, 2'd0, 3);
        exec("lw",      32'h0000A183, 1'b0, 2'd0, 2);
        exec("lbu",     32'h0010C183, 1'b0, 2'd1, 0);
    endtask

    task automatic test_jalr_reset;
        exec("jalr", 32'h000100E7, 1'b0, 2'd0, 0);
        do_fetch(32'h0000A183, 0, 1'b0);
        tick;
        tick;
        #1;
        checks++;
        if (mem_bus.mem_read !== 1'b1) begin
            errors++;
            $display("FAIL ld1_strobe: mem_read=%b, expected 1", mem_bus.mem_read);
        end
        rst_n = 1'b0;
        tick;
        checks++;
        if (mem_bus.mem_read !== 1'b0 || load_mar !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_access: mem_read=%b load_mar=%b, expected 0 1", mem_bus.mem_read, load_mar);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_illegal;
        do_fetch(32'h00000000, 0, 1'b0);
        tick;
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (load_pc !== 1'b0 || mem_bus.mem_read !== 1'b0 || mem_bus.mem_write !== 1'b0 ||
                (i > 0 && illegal_insn !== 1'b1)) begin
                errors++;
                $display("FAIL illegal_trap[%0d]: load_pc=%b rd=%b wr=%b illegal=%b, expected 0 0 0 1", i,
                         load_pc, mem_bus.mem_read, mem_bus.mem_write, illegal_insn);
            end
            tick;
        end
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        checks++;
        if (illegal_insn !== 1'b0) begin
            errors++;
            $display("FAIL illegal_clear: illegal=%b, expected 0", illegal_insn);
        end
`else
        #1;
        checks++;
        if (load_pc !== 1'b1 || pcmux_sel !== pc_plus4 || illegal_insn !== 1'b0 || mem_bus.mem_read !== 1'b0) begin
            errors++;
            $display("FAIL illegal_nop: load_pc=%b pcmux=%0d illegal=%b rd=%b, expected 1 0 0 0",
                     load_pc, pcmux_sel, illegal_insn, mem_bus.mem_read);
        end
        tick;
`endif
        exec("after_illegal", 32'h00500093, 1'b0, 2'd0, 0);
    endtask

    initial begin
        mem_bus.mem_resp = 1'b0;
        test_reset;
        test_fetch_handshake;
        test_alu;
        test_branch;
        test_mem;
        test_jalr_reset;
        test_illegal;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/control.md
Name: control

Overview:
- Multicycle control FSM that sequences the RV32I datapath: fetch, decode, execute, memory access and writeback for every RV32I instruction.
- Drives all datapath load enables and mux selects.
- Drives the memory read/write handshake.
- Sits beside the datapath in the CPU top level, between it and the memory port.

Parameters:
- None.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- opcode  in  7  rv32i_opcode from IR
- funct3  in  3  from IR
- funct7  in  7  from IR
- br_en  in  1  comparator result
- mem_offset  in  2  MAR[1:0]
- mem_resp  in  1  memory done, one-cycle pulse
- load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out  out  1 each  register loads
- pcmux_sel  out  2  0 = pc+4, 1 = alu_out, 2 = alu_out & ~1
- alumux1_sel  out  1  0 = rs1, 1 = pc
- alumux2_sel  out  3  0 = i_imm, 1 = u_imm, 2 = b_imm, 3 = s_imm, 4 = j_imm, 5 = rs2
- regfilemux_sel  out  3  0 = alu, 1 = zext br_en, 2 = u_imm, 3 = load data, 4 = pc+4
- loadmux_sel  out  3  0 = lb, 1 = lh, 2 = lw, 3 = lbu, 4 = lhu
- storemux_sel  out  2  0 = sb, 1 = sh, 2 = sw
- marmux_sel  out  1  0 = pc, 1 = alu_out
- cmpmux_sel  out  1  0 = rs2, 1 = i_imm
- aluop  out  alu_ops  ALU operation
- cmpop  out  branch_funct3_t  comparator operation
- mem_read, mem_write  out  1  memory strobes
- mem_byte_enable  out  4  write lane mask
- illegal_insn  out  1  sticky illegal-opcode flag

Behaviour:
- Default outputs every state: all loads 0, all selects 0, aluop = add, cmpop = funct3, mem strobes 0, byte_enable = 4'b1111.
- Reset is sampled on the clk edge. rst_n = 0 forces state FETCH1 and illegal_insn = 0. Because the strobes decode from state, mem_read/mem_write drop in the first cycle after reset, including reset taken mid-access.
- Memory handshake: the strobe is held high continuously until the cycle mem_resp = 1. The state advances on that edge. mem_resp outside a strobe state is ignored.
- FETCH1: marmux = 0, load_mar.
- FETCH2: mem_read. On mem_resp, load_mdr.
- FETCH3: load_ir.
- DECODE: branch on opcode to the execute state. Unknown opcode goes to ILLEGAL.
- IMM (op_imm), one cycle, ends with load_pc (pcmux = 0):
  - slti/sltiu: cmpmux = 1, cmpop = blt/bltu, regfilemux = 1.
  - srai: aluop = sra when funct7[5] = 1.
  - All others: aluop = funct3 mapping, alumux2 = 0.
  - load_regfile.
- REG (op_reg), one cycle, ends with load_pc (pcmux = 0):
  - alumux2 = 5.
  - sub/sra selected by funct7[5].
  - slt/sltu via cmp with cmpmux = 0.
  - load_regfile.
- LUI: regfilemux = 2, load_regfile, load_pc.
- AUIPC: alumux1 = 1, alumux2 = 1, add, load_regfile, load_pc.
- BR: alumux1 = 1, alumux2 = 2, add, cmpmux = 0, pcmux = br_en ? 1 : 0, load_pc.
- JAL: regfilemux = 4, load_regfile, alumux1 = 1, alumux2 = 4, pcmux = 1, load_pc.
- JALR: regfilemux = 4, load_regfile, alumux1 = 0, alumux2 = 0, pcmux = 2, load_pc. Both writes happen on the same edge, so pc+4 is taken from the old PC.
- CALC_ADDR: alumux1 = 0, add, marmux = 1, load_mar. alumux2 = 0 for load, 3 for store.
- LD1: mem_read. On mem_resp, load_mdr.
- LD2: regfilemux = 3, loadmux from funct3, load_regfile, load_pc (pcmux = 0).
- ST1: storemux from funct3, load_data_out. This runs after MAR is valid so mem_offset is correct.
- ST2: mem_write with byte enables:
  - sb: 4'b0001 << mem_offset
  - sh: 4'b0011 << {mem_offset[1], 1'b0}
  - sw: 4'b1111
  - On mem_resp, load_pc (pcmux = 0).
- Every execute path returns to FETCH1.
- Writes to x0 are suppressed by the regfile, not by this block.
- ILLEGAL: see Optional Feature.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: ILLEGAL sets illegal_insn = 1 and stays in ILLEGAL until reset. No loads and no memory strobes are issued while there.
- Undefined: ILLEGAL acts as a nop. It does load_pc (pcmux = 0), then goes to FETCH1. illegal_insn is tied to 0.

Decomposition:
- Package ctrl_types holds:
  - State enum.
  - Mux-select enums: pcmux_sel_t, alumux2_sel_t, regfilemux_sel_t, loadmux_sel_t, storemux_sel_t.
- rv32i_types::alu_ops, branch_funct3_t and opcode constants are reused as-is.
- One sub-module, ctrl_funct_decode: combinational map of funct3/funct7 to aluop, cmpop, loadmux_sel, storemux_sel and byte-enable shape.

Test Plan:
- Fetch handshake: hold mem_resp low 3 cycles in FETCH2 -> mem_read stays 1 throughout. Pulse mem_resp -> load_mdr = 1 that cycle, load_ir = 1 next cycle.
- Instruction 0x00500093 (addi x1, x0, 5): in IMM expect aluop = add, alumux2 = 0, regfilemux = 0, load_regfile = 1, load_pc = 1 with pcmux = 0.
- beq taken, then not taken, br_en driven: taken -> pcmux = 1, alumux2 = 2; not taken -> pcmux = 0. Both cycles assert load_pc.
- sb with MAR = 0x...03 -> mem_byte_enable = 4'b1000. sh with MAR = 0x...02 -> 4'b1100. sw -> 4'b1111. mem_write holds until mem_resp.
- jalr: expect pcmux = 2, regfilemux = 4, load_regfile and load_pc in the same cycle. Then rst_n = 0 during LD1 -> next cycle mem_read = 0 and state = FETCH1.
- Opcode 7'b0000000: with CTRL_ILLEGAL_TRAP_EN, illegal_insn = 1 and no further load_pc for 10 cycles. Without the macro, load_pc = 1 and fetch resumes.
